// File: rtl/div_unit_pkg.sv
// Shared defines for the EX-stage divider: FSM state codes and control-level constants.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b1;

  localparam logic [5:0] DivSteps = 6'd32;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: trial-subtract the divisor from the upper partial
// remainder and shift in the resulting quotient bit.
module div_step (
  input  logic [64:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [64:0] o_dividend
);

  logic [32:0] w_diff;

  assign w_diff     = {1'b0, i_dividend[63:32]} - {1'b0, i_divisor};
  assign o_dividend = w_diff[32] ? {i_dividend[63:0], 1'b0}
                                 : {w_diff[31:0], i_dividend[31:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, result {remainder, quotient} after 32 steps.
// Signed DIV support is built only when DIV_SIGNED_EN is defined; otherwise all divides are unsigned.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  r_state, w_state_n;
  logic [5:0]  r_cnt, w_cnt_n;
  logic [64:0] r_dividend, w_dividend_n, w_step;
  logic [31:0] r_divisor, w_divisor_n;
  logic [63:0] r_result, w_result_n;
  logic        r_ready, w_ready_n;
  logic [31:0] w_op_a, w_op_b, w_quo, w_rem;

`ifdef DIV_SIGNED_EN
  logic r_neg_quo, r_neg_rem, w_neg_quo_n, w_neg_rem_n;

  assign w_op_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  assign w_quo  = r_neg_quo ? (~r_dividend[31:0] + 32'd1) : r_dividend[31:0];
  assign w_rem  = r_neg_rem ? (~r_dividend[64:33] + 32'd1) : r_dividend[64:33];
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_div_i;
  assign w_op_a = opdata1_i;
  assign w_op_b = opdata2_i;
  assign w_quo  = r_dividend[31:0];
  assign w_rem  = r_dividend[64:33];
`endif

  div_step u_step (
    .i_dividend (r_dividend),
    .i_divisor  (r_divisor),
    .o_dividend (w_step)
  );

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_dividend_n = r_dividend;
    w_divisor_n  = r_divisor;
    w_result_n   = r_result;
    w_ready_n    = r_ready;
`ifdef DIV_SIGNED_EN
    w_neg_quo_n  = r_neg_quo;
    w_neg_rem_n  = r_neg_rem;
`endif
    case (r_state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          w_cnt_n = 6'd0;
          if (opdata2_i == 32'd0) begin
            w_state_n = DivByZero;
          end else begin
            w_state_n    = DivOn;
            w_dividend_n = {32'd0, w_op_a, 1'b0};
            w_divisor_n  = w_op_b;
`ifdef DIV_SIGNED_EN
            w_neg_quo_n  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            w_neg_rem_n  = signed_div_i & opdata1_i[31];
`endif
          end
        end
      end
      DivByZero: begin
        // Held for two cycles so ready_o lands after edge 2 of the request.
        if (annul_i) begin
          w_state_n = DivFree;
        end else if (r_cnt == 6'd0) begin
          w_cnt_n = 6'd1;
        end else begin
          w_result_n = 64'h0;
          w_ready_n  = DivResultReady;
          w_state_n  = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          w_state_n = DivFree;
          w_cnt_n   = 6'd0;
        end else if (r_cnt != DivSteps) begin
          w_dividend_n = w_step;
          w_cnt_n      = r_cnt + 6'd1;
        end else begin
          w_result_n = {w_rem, w_quo};
          w_ready_n  = DivResultReady;
          w_state_n  = DivEnd;
          w_cnt_n    = 6'd0;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          w_state_n  = DivFree;
          w_ready_n  = DivResultNotReady;
          w_result_n = 64'h0;
        end
      end
      default: w_state_n = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state    <= DivFree;
      r_cnt      <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_result   <= 64'h0;
      r_ready    <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      r_neg_quo  <= 1'b0;
      r_neg_rem  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_dividend <= w_dividend_n;
      r_divisor  <= w_divisor_n;
      r_result   <= w_result_n;
      r_ready    <= w_ready_n;
`ifdef DIV_SIGNED_EN
      r_neg_quo  <= w_neg_quo_n;
      r_neg_rem  <= w_neg_rem_n;
`endif
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = (start_i && !annul_i && r_state != DivEnd) ? Stop : NoStop;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a result scoreboard queue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one divide with start held, measure stall and latency, then release start.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int exp_lat,
                         input int exp_stall);
    int n;
    int stall;
    logic [63:0] e;
    @(negedge clk);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = sgn;
    start_i = 1'b1;
    exp_q.push_back(exp);
    n = 0;
    stall = 0;
    #1;
    while (!ready_o && n < 200) begin
      if (stallreq_o) stall++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(n - 1), 64'(exp_lat));
    check({tag, " stall cycles"}, 64'(stall), 64'(exp_stall));
    check({tag, " stall at ready"}, 64'(stallreq_o), 64'd0);
    e = exp_q.pop_front();
    check({tag, " result"}, result_o, e);
    @(posedge clk);
    @(negedge clk);
    check({tag, " result held"}, result_o, e);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready cleared"}, 64'(ready_o), 64'd0);
    check({tag, " result cleared"}, result_o, 64'h0);
  endtask

  task automatic wait_edges(input int k);
    for (int i = 0; i < k; i++) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    wait_edges(2);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'h0);
    check("reset stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    wait_edges(1);

    run_div("10/3", 32'd10, 32'd3, 1'b0, 64'h00000001_00000003, 33, 34);

`ifdef DIV_SIGNED_EN
    run_div("-7/2", 32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 34);
    run_div("minneg/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 34);
    run_div("-7/2 divu", 32'hFFFFFFF9, 32'h2, 1'b0, 64'h00000001_7FFFFFFC, 33, 34);
`else
    run_div("-7/2", 32'hFFFFFFF9, 32'h2, 1'b1, 64'h00000001_7FFFFFFC, 33, 34);
    run_div("minneg/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h80000000_00000000, 33, 34);
`endif

    run_div("div by zero", 32'h12345678, 32'd0, 1'b0, 64'h0, 2, 3);

    // Annul mid-divide at cnt=10.
    @(negedge clk);
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    wait_edges(11);
    annul_i = 1'b1;
    #1;
    check("annul masks stall", 64'(stallreq_o), 64'd0);
    wait_edges(1);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul stall", 64'(stallreq_o), 64'd0);
    wait_edges(40);
    check("annul no late ready", 64'(ready_o), 64'd0);
    check("annul result", result_o, 64'h0);
    run_div("100/7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 34);

    // Start and annul together in IDLE: annul wins.
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    annul_i = 1'b1;
    wait_edges(3);
    start_i = 1'b0;
    annul_i = 1'b0;
    wait_edges(1);
    check("start+annul idle ready", 64'(ready_o), 64'd0);

    // Synchronous reset at cnt=20.
    @(negedge clk);
    opdata1_i = 32'h0000DEAD;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    wait_edges(21);
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("mid reset ready", 64'(ready_o), 64'd0);
    check("mid reset result", result_o, 64'h0);
    run_div("ffffffff/1", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 34);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      run_div("random divu", ra, rb, 1'b0, {ra % rb, ra / rb}, 33, 34);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
